// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type, default sizes and address-width helper
// for the JAMIA multi-port integer register file.
package regfile_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    function automatic int rf_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits. Writes clear, a reservation sets
// (and wins over a same-cycle write), clear_req wipes the whole vector.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = RF_NREGS,
    parameter  int NWR   = 1,
    localparam int AW    = rf_aw(NREGS)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              i_clear,
    input  logic              i_rsv_en,
    input  logic [AW-1:0]     i_rsv_addr,
    input  logic [NWR-1:0]    i_wr_en,
    input  logic [NWR*AW-1:0] i_wr_addr,
    output logic [NREGS-1:0]  o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // NOTE: default assignment first so every path drives w_busy_nxt (no latch).
    always_comb begin
        w_busy_nxt = r_busy;
        for (int p = 0; p < NWR; p++) begin
            if (i_wr_en[p]) w_busy_nxt[i_wr_addr[p*AW +: AW]] = 1'b0;
        end
        if (i_rsv_en) w_busy_nxt[i_rsv_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)    r_busy <= '0;
        else if (i_clear) r_busy <= '0;
        else              r_busy <= w_busy_nxt;
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write register file with busy scoreboard and a
// post-reset clearing sweep. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = RF_XLEN,
    parameter  int NREGS = RF_NREGS,
    parameter  int NRD   = 2,
    parameter  int NWR   = 1,
    localparam int AW    = rf_aw(NREGS)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                clear_req_in,
    output logic                ready_out,
    input  logic [NRD*AW-1:0]   rs_addr_in,
    output logic [NRD*XLEN-1:0] rs_data_out,
    output logic [NRD-1:0]      rs_busy_out,
    input  logic                rsv_en_in,
    input  logic [AW-1:0]       rsv_addr_in,
    input  logic [NWR-1:0]      wr_en_in,
    input  logic [NWR*AW-1:0]   wr_addr_in,
    input  logic [NWR*XLEN-1:0] wr_data_in
);

    rf_state_e        r_state;
    logic [AW-1:0]    r_ptr;
    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NREGS-1:0] w_busy;
    logic             w_run;
    logic [NWR-1:0]   w_wr_en;
    logic             w_rsv_en;

    assign w_run     = (r_state == RF_RUN);
    assign ready_out = w_run;

    // Writes and reservations are only honoured in RUN, and never to x0.
    always_comb begin
        w_wr_en = '0;
        for (int p = 0; p < NWR; p++) begin
            w_wr_en[p] = w_run && wr_en_in[p] && (wr_addr_in[p*AW +: AW] != '0);
        end
    end
    assign w_rsv_en = w_run && rsv_en_in && (rsv_addr_in != '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= RF_INIT;
            r_ptr   <= AW'(1);
        end else if (clear_req_in) begin
            r_state <= RF_INIT;
            r_ptr   <= AW'(1);
        end else if (r_state == RF_INIT) begin
            if (r_ptr == AW'(NREGS - 1)) r_state <= RF_RUN;
            else                         r_ptr   <= r_ptr + AW'(1);
        end
    end

    // NOTE: the array has no reset; the INIT sweep zeroes it one entry per cycle.
    always_ff @(posedge clk_in) begin
        if (r_state == RF_INIT) begin
            r_mem[r_ptr] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (w_wr_en[p]) r_mem[wr_addr_in[p*AW +: AW]] <= wr_data_in[p*XLEN +: XLEN];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .i_clear    (clear_req_in),
        .i_rsv_en   (w_rsv_en),
        .i_rsv_addr (rsv_addr_in),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (wr_addr_in),
        .o_busy     (w_busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_busy_rd;

        assign w_addr = rs_addr_in[k*AW +: AW];

        // Later write ports overwrite earlier matches, so the highest index wins.
        always_comb begin
            w_data    = (w_addr == '0) ? '0 : r_mem[w_addr];
            w_busy_rd = w_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NWR; p++) begin
                if (w_wr_en[p] && (wr_addr_in[p*AW +: AW] == w_addr)) begin
                    w_data    = wr_data_in[p*XLEN +: XLEN];
                    w_busy_rd = w_rsv_en && (rsv_addr_in == w_addr);
                end
            end
`endif
            if (!w_run) w_busy_rd = 1'b1;
        end

        assign rs_data_out[k*XLEN +: XLEN] = w_data;
        assign rs_busy_out[k]              = w_busy_rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed tests for regfile_mp (NRD=2, NWR=2), valid with or
// without REGFILE_BYPASS_EN.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        clear_req_in;
    logic        ready_out;
    logic [9:0]  rs_addr_in;
    logic [63:0] rs_data_out;
    logic [1:0]  rs_busy_out;
    logic        rsv_en_in;
    logic [4:0]  rsv_addr_in;
    logic [1:0]  wr_en_in;
    logic [9:0]  wr_addr_in;
    logic [63:0] wr_data_in;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp #(
        .XLEN  (32),
        .NREGS (32),
        .NRD   (2),
        .NWR   (2)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .clear_req_in (clear_req_in),
        .ready_out    (ready_out),
        .rs_addr_in   (rs_addr_in),
        .rs_data_out  (rs_data_out),
        .rs_busy_out  (rs_busy_out),
        .rsv_en_in    (rsv_en_in),
        .rsv_addr_in  (rsv_addr_in),
        .wr_en_in     (wr_en_in),
        .wr_addr_in   (wr_addr_in),
        .wr_data_in   (wr_data_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        clear_req_in = 1'b0;
        rsv_en_in    = 1'b0;
        rsv_addr_in  = '0;
        wr_en_in     = '0;
        wr_addr_in   = '0;
        wr_data_in   = '0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (ready_out !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst_n_in   = 1'b0;
        rs_addr_in = '0;
        idle();
        repeat (3) tick();
        n_tests++;
        if (ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b exp 0", ready_out);
        end
        n_tests++;
        if (rs_busy_out !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_busy: got %b exp 11", rs_busy_out);
        end
        rst_n_in = 1'b1;
        wait_ready(cyc);
        n_tests++;
        if (cyc != 31) begin
            n_fail++;
            $display("FAIL reset_sweep_len: got %0d exp 31", cyc);
        end
        rs_addr_in = {5'd0, 5'd5};
        #1;
        n_tests++;
        if (rs_data_out[31:0] !== 32'h0 || rs_busy_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_x5: got data %h busy %b exp 0 0", rs_data_out[31:0], rs_busy_out[0]);
        end
        n_tests++;
        if (rs_data_out[63:32] !== 32'h0 || rs_busy_out[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_x0: got data %h busy %b exp 0 0", rs_data_out[63:32], rs_busy_out[1]);
        end
    endtask

    task automatic test_write_bypass();
        logic [31:0] exp_d;
        rs_addr_in = {5'd0, 5'd7};
        wr_en_in   = 2'b01;
        wr_addr_in = {5'd0, 5'd7};
        wr_data_in = {32'h0, 32'hDEAD_BEEF};
        #1;
        exp_d = BYP ? 32'hDEAD_BEEF : 32'h0;
        n_tests++;
        if (rs_data_out[31:0] !== exp_d || rs_busy_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_same_cycle x7: got %h busy %b exp %h busy 0", rs_data_out[31:0], rs_busy_out[0], exp_d);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (rs_data_out[31:0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wr_next_cycle x7: got %h exp deadbeef", rs_data_out[31:0]);
        end
    endtask

    task automatic test_multi_write();
        logic [31:0] exp_d;
        rs_addr_in = {5'd3, 5'd7};
        wr_en_in   = 2'b11;
        wr_addr_in = {5'd3, 5'd3};
        wr_data_in = {32'h2222, 32'h1111};
        #1;
        exp_d = BYP ? 32'h2222 : 32'h0;
        n_tests++;
        if (rs_data_out[63:32] !== exp_d) begin
            n_fail++;
            $display("FAIL multi_wr_same_cycle x3: got %h exp %h", rs_data_out[63:32], exp_d);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (rs_data_out[63:32] !== 32'h2222 || rs_data_out[31:0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL multi_wr x3/x7: got %h/%h exp 2222/deadbeef", rs_data_out[63:32], rs_data_out[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        logic [31:0] exp_d;
        logic        exp_b;
        rs_addr_in  = {5'd0, 5'd9};
        rsv_en_in   = 1'b1;
        rsv_addr_in = 5'd9;
        #1;
        n_tests++;
        if (rs_busy_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_same_cycle x9 busy: got %b exp 0", rs_busy_out[0]);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (rs_busy_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv_next_cycle x9 busy: got %b exp 1", rs_busy_out[0]);
        end
        rsv_en_in   = 1'b1;
        rsv_addr_in = 5'd9;
        wr_en_in    = 2'b01;
        wr_addr_in  = {5'd0, 5'd9};
        wr_data_in  = {32'h0, 32'h55};
        #1;
        exp_d = BYP ? 32'h55 : 32'h0;
        n_tests++;
        if (rs_busy_out[0] !== 1'b1 || rs_data_out[31:0] !== exp_d) begin
            n_fail++;
            $display("FAIL rsv_wr_same_cycle x9: got %h busy %b exp %h busy 1", rs_data_out[31:0], rs_busy_out[0], exp_d);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (rs_busy_out[0] !== 1'b1 || rs_data_out[31:0] !== 32'h55) begin
            n_fail++;
            $display("FAIL rsv_wins x9: got %h busy %b exp 55 busy 1", rs_data_out[31:0], rs_busy_out[0]);
        end
        wr_en_in   = 2'b10;
        wr_addr_in = {5'd9, 5'd0};
        wr_data_in = {32'h66, 32'h0};
        #1;
        exp_b = BYP ? 1'b0 : 1'b1;
        n_tests++;
        if (rs_busy_out[0] !== exp_b) begin
            n_fail++;
            $display("FAIL wr_clear_same_cycle x9 busy: got %b exp %b", rs_busy_out[0], exp_b);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (rs_busy_out[0] !== 1'b0 || rs_data_out[31:0] !== 32'h66) begin
            n_fail++;
            $display("FAIL wr_clears x9: got %h busy %b exp 66 busy 0", rs_data_out[31:0], rs_busy_out[0]);
        end
    endtask

    task automatic test_x0();
        rs_addr_in  = {5'd0, 5'd0};
        wr_en_in    = 2'b01;
        wr_addr_in  = {5'd0, 5'd0};
        wr_data_in  = {32'h0, 32'hFFFF_FFFF};
        rsv_en_in   = 1'b1;
        rsv_addr_in = 5'd0;
        #1;
        n_tests++;
        if (rs_data_out[31:0] !== 32'h0 || rs_busy_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_same_cycle: got %h busy %b exp 0 busy 0", rs_data_out[31:0], rs_busy_out[0]);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (rs_data_out[31:0] !== 32'h0 || rs_busy_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_after: got %h busy %b exp 0 busy 0", rs_data_out[31:0], rs_busy_out[0]);
        end
    endtask

    task automatic test_clear();
        int cyc;
        rs_addr_in = {5'd6, 5'd4};
        wr_en_in   = 2'b01;
        wr_addr_in = {5'd0, 5'd4};
        wr_data_in = {32'h0, 32'hABCD};
        tick();
        idle();
        rsv_en_in   = 1'b1;
        rsv_addr_in = 5'd6;
        tick();
        idle();
        #1;
        n_tests++;
        if (rs_data_out[31:0] !== 32'hABCD || rs_busy_out[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_clear x4/x6: got %h busy %b exp abcd busy 1", rs_data_out[31:0], rs_busy_out[1]);
        end
        clear_req_in = 1'b1;
        tick();
        clear_req_in = 1'b0;
        n_tests++;
        if (ready_out !== 1'b0 || rs_busy_out !== 2'b11) begin
            n_fail++;
            $display("FAIL clear_enter_init: got ready %b busy %b exp 0 11", ready_out, rs_busy_out);
        end
        wr_en_in    = 2'b11;
        wr_addr_in  = {5'd4, 5'd4};
        wr_data_in  = {32'h1234, 32'h5678};
        rsv_en_in   = 1'b1;
        rsv_addr_in = 5'd6;
        wait_ready(cyc);
        idle();
        #1;
        n_tests++;
        if (cyc != 31) begin
            n_fail++;
            $display("FAIL clear_sweep_len: got %0d exp 31", cyc);
        end
        n_tests++;
        if (rs_data_out[31:0] !== 32'h0 || rs_busy_out !== 2'b00) begin
            n_fail++;
            $display("FAIL post_clear x4/x6: got %h busy %b exp 0 busy 00", rs_data_out[31:0], rs_busy_out);
        end
    endtask

    task automatic test_clear_restart();
        int cyc;
        clear_req_in = 1'b1;
        tick();
        clear_req_in = 1'b0;
        repeat (5) tick();
        clear_req_in = 1'b1;
        tick();
        clear_req_in = 1'b0;
        wait_ready(cyc);
        n_tests++;
        if (cyc != 31) begin
            n_fail++;
            $display("FAIL init_clear_restart_len: got %0d exp 31", cyc);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        rs_addr_in = {5'd0, 5'd4};
        wr_en_in   = 2'b01;
        wr_addr_in = {5'd0, 5'd4};
        wr_data_in = {32'h0, 32'h77};
        tick();
        idle();
        #1;
        n_tests++;
        if (rs_data_out[31:0] !== 32'h77) begin
            n_fail++;
            $display("FAIL pre_reset x4: got %h exp 77", rs_data_out[31:0]);
        end
        clear_req_in = 1'b1;
        tick();
        clear_req_in = 1'b0;
        repeat (10) tick();
        rst_n_in = 1'b0;
        #2;
        n_tests++;
        if (ready_out !== 1'b0 || rs_busy_out !== 2'b11) begin
            n_fail++;
            $display("FAIL async_reset: got ready %b busy %b exp 0 11", ready_out, rs_busy_out);
        end
        tick();
        rst_n_in = 1'b1;
        wait_ready(cyc);
        #1;
        n_tests++;
        if (cyc != 31) begin
            n_fail++;
            $display("FAIL mid_sweep_reset_len: got %0d exp 31", cyc);
        end
        n_tests++;
        if (rs_data_out[31:0] !== 32'h0 || rs_busy_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset x4: got %h busy %b exp 0 busy 0", rs_data_out[31:0], rs_busy_out[0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_multi_write();
        test_scoreboard();
        test_x0();
        test_clear();
        test_clear_restart();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
